// File: rtl/chess_clock_pkg.sv
// Shared types and BCD digit helper for the chess clock timer.
package chess_clock_pkg;

  typedef logic [3:0] t_bcd;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLAG
  } t_timer_state;

  localparam t_bcd BCD_SEC_TENS_MAX = 4'd5;
  localparam t_bcd BCD_DIGIT_MAX    = 4'd9;

  // Returns {carry/borrow, new digit} for one BCD digit rolling at lim.
  function automatic logic [4:0] bcd_digit_step(
    input t_bcd d,
    input t_bcd lim,
    input logic up
  );
    if (up)
      return (d == lim) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
    return (d == 4'd0) ? {1'b1, lim} : {1'b0, d - 4'd1};
  endfunction

endpackage

// File: rtl/bcd_mmss_step.sv
// Combinational +1 / -1 second on a BCD mm:ss value.
// Holds at 00:00 on -1 and saturates at the all-9:59 maximum on +1.
module bcd_mmss_step
  import chess_clock_pkg::*;
#(
  parameter int p_min_digits = 2
) (
  input  logic [p_min_digits-1:0][3:0] cur_min,
  input  logic [1:0][3:0]              cur_sec,
  input  logic                         up,
  output logic [p_min_digits-1:0][3:0] nxt_min,
  output logic [1:0][3:0]              nxt_sec,
  output logic                         is_zero,
  output logic                         is_max
);

  logic       all_nine;
  logic       c;
  logic [4:0] r;

  always_comb begin
    all_nine = 1'b1;
    for (int i = 0; i < p_min_digits; i++)
      if (cur_min[i] != BCD_DIGIT_MAX) all_nine = 1'b0;
    is_zero = (cur_min == '0) && (cur_sec == '0);
    is_max  = all_nine
           && (cur_sec[1] == BCD_SEC_TENS_MAX)
           && (cur_sec[0] == BCD_DIGIT_MAX);
    nxt_min = cur_min;
    nxt_sec = cur_sec;
    r       = '0;
    c       = up ? !is_max : !is_zero;
    for (int i = 0; i < 2; i++) begin
      if (c) begin
        r = bcd_digit_step(cur_sec[i],
              (i == 0) ? BCD_DIGIT_MAX : BCD_SEC_TENS_MAX, up);
        nxt_sec[i] = r[3:0];
        c = r[4];
      end
    end
    for (int i = 0; i < p_min_digits; i++) begin
      if (c) begin
        r = bcd_digit_step(cur_min[i], BCD_DIGIT_MAX, up);
        nxt_min[i] = r[3:0];
        c = r[4];
      end
    end
  end

endmodule

// File: rtl/chess_clock_timer.sv
// Per-player mm:ss BCD countdown with prescaler, sticky flag and low warning.
// Optional Fischer increment enabled by defining CHESS_CLOCK_INCREMENT_EN.
module chess_clock_timer
  import chess_clock_pkg::*;
#(
  parameter int p_divider    = 50_000_000,
  parameter int p_min_digits = 2,
  parameter int p_low_sec    = 10,
  parameter int p_increment  = 5
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_load,
  input  logic [p_min_digits-1:0][3:0] i_init_min,
  input  logic [1:0][3:0]              i_init_sec,
  input  logic                         i_run,
  input  logic                         i_turn_end,
  output logic [p_min_digits-1:0][3:0] o_min,
  output logic [1:0][3:0]              o_sec,
  output logic                         o_zero,
  output logic                         o_running,
  output logic                         o_low
);

  localparam int PW = $clog2(p_divider);
  localparam logic [PW-1:0] PRESC_LAST = PW'(p_divider - 1);

  t_timer_state                 state;
  logic [PW-1:0]                presc;
  logic [p_min_digits-1:0][3:0] nxt_min;
  logic [1:0][3:0]              nxt_sec;
  logic                         is_zero;
  logic                         at_max;
  logic                         run_en;
  logic                         tick;
  logic                         inc_go;
  logic                         step_up;
  logic                         nxt_zero;
  logic                         sec_low;

  assign run_en = i_run && (state == S_RUN
               || (state == S_IDLE && !is_zero));
  assign tick     = run_en && (presc == PRESC_LAST);
  assign step_up  = inc_go && !tick;
  assign nxt_zero = (nxt_min == '0) && (nxt_sec == '0);

  bcd_mmss_step #(
    .p_min_digits(p_min_digits)
  ) u_step (
    .cur_min(o_min),
    .cur_sec(o_sec),
    .up     (step_up),
    .nxt_min(nxt_min),
    .nxt_sec(nxt_sec),
    .is_zero(is_zero),
    .is_max (at_max)
  );

`ifdef CHESS_CLOCK_INCREMENT_EN
  logic [7:0] pend;
  logic [7:0] pend_nxt;
  logic [8:0] pend_sum;

  assign inc_go = (pend != '0) && (state != S_FLAG);

  always_comb begin
    pend_sum = {1'b0, pend};
    if (inc_go) pend_sum = pend_sum - 9'd1;
    if (step_up && at_max) pend_sum = '0;
    if (i_turn_end && state != S_FLAG)
      pend_sum = pend_sum + 9'(p_increment);
    pend_nxt = pend_sum[8] ? 8'hff : pend_sum[7:0];
    // Flag-fall swallows any increment arriving with it.
    if (tick && !inc_go && nxt_zero) pend_nxt = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)      pend <= '0;
    else if (i_load) pend <= '0;
    else             pend <= pend_nxt;
  end
`else
  logic unused_cfg;
  assign inc_go     = 1'b0;
  assign unused_cfg = ^{at_max, i_turn_end, (p_increment != 0)};
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state  <= S_IDLE;
      presc  <= '0;
      o_min  <= '0;
      o_sec  <= '0;
      o_zero <= 1'b0;
    end else if (i_load) begin
      state  <= S_IDLE;
      presc  <= '0;
      o_min  <= i_init_min;
      o_sec  <= i_init_sec;
      o_zero <= 1'b0;
    end else if (state != S_FLAG) begin
      state <= run_en ? S_RUN : S_IDLE;
      if (run_en) presc <= tick ? '0 : presc + 1'b1;
      // A tick and a pending second cancel each other out.
      if (tick != inc_go) begin
        o_min <= nxt_min;
        o_sec <= nxt_sec;
      end
      if (tick && !inc_go && nxt_zero) begin
        o_zero <= 1'b1;
        state  <= S_FLAG;
      end
    end
  end

  assign o_running = (state == S_RUN);
  assign sec_low = ({4'd0, o_sec[1]} * 8'd10 + {4'd0, o_sec[0]})
                 < 8'(p_low_sec);
  // 00:00 outside FLAG is an unloaded clock, not a low one.
  assign o_low = (o_min == '0) && sec_low && !o_zero && !is_zero;

endmodule
